// File: rtl/fwd_hazard_ctrl_if.sv
// Forwarding/hazard controller bus: pipeline-side inputs and select/stall outputs.
// Optional perf outputs exist only when FWD_HAZARD_PERF_EN is defined.
interface fwd_hazard_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int XLEN    = 32
);
  logic                      hold_i;
  logic                      flush_i;
  logic                      id_vld_i;
  logic [NUM_SRC*REG_AW-1:0] rs_id_i;
  logic [NUM_SRC-1:0]        use_ex_i;
  logic [NUM_SRC-1:0]        use_cmp_i;
  logic [NUM_SRC*REG_AW-1:0] rs_ex_i;
  logic                      regwr_ex_i;
  logic                      memrd_ex_i;
  logic [REG_AW-1:0]         rd_ex_i;
  logic                      regwr_me_i;
  logic                      memrd_me_i;
  logic [REG_AW-1:0]         rd_me_i;
  logic                      regwr_wb_i;
  logic [REG_AW-1:0]         rd_wb_i;
  logic [XLEN-1:0]           wb_data_i;
  logic [2*NUM_SRC-1:0]      fw_ex_sel_o;
  logic [2*NUM_SRC-1:0]      fw_id_sel_o;
  logic [XLEN-1:0]           hist_data_o;
  logic                      stall_o;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]               perf_stall_cnt_o;
  logic [31:0]               perf_ld_use_o;
`endif

  modport master (
    output hold_i, flush_i, id_vld_i, rs_id_i, use_ex_i, use_cmp_i, rs_ex_i,
           regwr_ex_i, memrd_ex_i, rd_ex_i, regwr_me_i, memrd_me_i, rd_me_i,
           regwr_wb_i, rd_wb_i, wb_data_i,
`ifdef FWD_HAZARD_PERF_EN
    input  perf_stall_cnt_o, perf_ld_use_o,
`endif
    input  fw_ex_sel_o, fw_id_sel_o, hist_data_o, stall_o
  );

  modport slave (
    input  hold_i, flush_i, id_vld_i, rs_id_i, use_ex_i, use_cmp_i, rs_ex_i,
           regwr_ex_i, memrd_ex_i, rd_ex_i, regwr_me_i, memrd_me_i, rd_me_i,
           regwr_wb_i, rd_wb_i, wb_data_i,
`ifdef FWD_HAZARD_PERF_EN
    output perf_stall_cnt_o, perf_ld_use_o,
`endif
    output fw_ex_sel_o, fw_id_sel_o, hist_data_o, stall_o
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding + load-use/compare-use hazard control for a 5-stage RV32I pipe; selects are
// combinational, stalls last 0-2 cycles, hold_i freezes state. Perf counters: FWD_HAZARD_PERF_EN.
module fwd_hazard_ctrl #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int XLEN    = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  fwd_hazard_ctrl_if.slave bus
);
  typedef enum logic {ST_IDLE, ST_STALL} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              stall_hold_q, stall_hold_d;
  logic              hist_vld_q, hist_vld_d;
  logic [REG_AW-1:0] hist_rd_q, hist_rd_d;
  logic [XLEN-1:0]   hist_data_q, hist_data_d;

  logic [2*NUM_SRC-1:0] fw_ex_sel, fw_id_sel;
  logic [1:0]           r_req;
  logic                 ld_cause;
  logic                 stall_c;
  logic                 ld_entry;
  logic [REG_AW-1:0]    a_ex, a_id;

  function automatic logic hit(input logic wr, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] a);
    return wr && (rd != '0) && (rd == a);
  endfunction

  always_comb begin
    fw_ex_sel = '0;
    fw_id_sel = '0;
    r_req     = 2'd0;
    ld_cause  = 1'b0;
    a_ex      = '0;
    a_id      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      a_ex = bus.rs_ex_i[k*REG_AW +: REG_AW];
      a_id = bus.rs_id_i[k*REG_AW +: REG_AW];

      // a load sitting in ME has no data yet, so it never forwards
      if (hit(bus.regwr_me_i && !bus.memrd_me_i, bus.rd_me_i, a_ex))
        fw_ex_sel[2*k +: 2] = 2'd1;
      else if (hit(bus.regwr_wb_i, bus.rd_wb_i, a_ex))
        fw_ex_sel[2*k +: 2] = 2'd2;
      else if (hit(hist_vld_q, hist_rd_q, a_ex))
        fw_ex_sel[2*k +: 2] = 2'd3;

      if (hit(bus.regwr_me_i && !bus.memrd_me_i, bus.rd_me_i, a_id))
        fw_id_sel[2*k +: 2] = 2'd1;
      else if (hit(bus.regwr_wb_i, bus.rd_wb_i, a_id))
        fw_id_sel[2*k +: 2] = 2'd2;

      if (bus.id_vld_i && (bus.use_ex_i[k] || bus.use_cmp_i[k])) begin
        if (hit(bus.regwr_ex_i && bus.memrd_ex_i, bus.rd_ex_i, a_id)) begin
          r_req    = 2'd2;
          ld_cause = 1'b1;
        end
        if (hit(bus.regwr_me_i && bus.memrd_me_i, bus.rd_me_i, a_id)) begin
          if (r_req == 2'd0) r_req = 2'd1;
          ld_cause = 1'b1;
        end
        if (bus.use_cmp_i[k] && hit(bus.regwr_ex_i && !bus.memrd_ex_i, bus.rd_ex_i, a_id))
          if (r_req == 2'd0) r_req = 2'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    ld_entry = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (r_req != 2'd0) begin
          stall_c  = 1'b1;
          cnt_d    = 2'(r_req - 2'd1);
          ld_entry = ld_cause;
          if (r_req > 2'd1) state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        stall_c = 1'b1;
        cnt_d   = 2'(cnt_q - 2'd1);
        if (cnt_q <= 2'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush_i) begin
      state_d  = ST_IDLE;
      cnt_d    = 2'd0;
      stall_c  = 1'b0;
      ld_entry = 1'b0;
    end
    // a frozen pipe keeps presenting the stall level it had before the freeze
    if (bus.hold_i) begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall_c  = stall_hold_q;
      ld_entry = 1'b0;
    end
    stall_hold_d = stall_c;
  end

  always_comb begin
    hist_vld_d  = hist_vld_q;
    hist_rd_d   = hist_rd_q;
    hist_data_d = hist_data_q;
    if (!bus.hold_i) begin
      hist_vld_d  = bus.regwr_wb_i && (bus.rd_wb_i != '0);
      hist_rd_d   = bus.rd_wb_i;
      hist_data_d = bus.wb_data_i;
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_ld_q, perf_ld_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_c && !bus.hold_i};
    perf_ld_d    = perf_ld_q + {31'd0, ld_entry};
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      stall_hold_q <= 1'b0;
      hist_vld_q   <= 1'b0;
      hist_rd_q    <= '0;
      hist_data_q  <= '0;
`ifdef FWD_HAZARD_PERF_EN
      perf_stall_q <= '0;
      perf_ld_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stall_hold_q <= stall_hold_d;
      hist_vld_q   <= hist_vld_d;
      hist_rd_q    <= hist_rd_d;
      hist_data_q  <= hist_data_d;
`ifdef FWD_HAZARD_PERF_EN
      perf_stall_q <= perf_stall_d;
      perf_ld_q    <= perf_ld_d;
`endif
    end
  end

  assign bus.fw_ex_sel_o = rst_n_i ? fw_ex_sel   : '0;
  assign bus.fw_id_sel_o = rst_n_i ? fw_id_sel   : '0;
  assign bus.hist_data_o = rst_n_i ? hist_data_q : '0;
  assign bus.stall_o     = rst_n_i ? stall_c     : 1'b0;
`ifdef FWD_HAZARD_PERF_EN
  assign bus.perf_stall_cnt_o = rst_n_i ? perf_stall_q : '0;
  assign bus.perf_ld_use_o    = rst_n_i ? perf_ld_q    : '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl with hand-computed expectations.
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.NUM_SRC(2), .REG_AW(5), .XLEN(32)) bus ();
  fwd_hazard_ctrl #(.NUM_SRC(2), .REG_AW(5), .XLEN(32)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.hold_i = 0; bus.flush_i = 0; bus.id_vld_i = 0;
    bus.rs_id_i = '0; bus.use_ex_i = '0; bus.use_cmp_i = '0; bus.rs_ex_i = '0;
    bus.regwr_ex_i = 0; bus.memrd_ex_i = 0; bus.rd_ex_i = '0;
    bus.regwr_me_i = 0; bus.memrd_me_i = 0; bus.rd_me_i = '0;
    bus.regwr_wb_i = 0; bus.rd_wb_i = '0; bus.wb_data_i = '0;
  endtask

  // advance past the next rising edge, clear inputs
  task automatic next_cyc();
    @(posedge clk);
    #2;
    clr();
  endtask

  task automatic ex_load(input logic [4:0] rd);
    bus.regwr_ex_i = 1; bus.memrd_ex_i = 1; bus.rd_ex_i = rd;
  endtask

  initial begin
    rst_n = 0;
    clr();
    // reset with a live ME match on the inputs
    bus.regwr_me_i = 1; bus.rd_me_i = 5'd4; bus.rs_ex_i = {5'd0, 5'd4};
    ex_load(5'd4); bus.id_vld_i = 1; bus.rs_id_i = {5'd0, 5'd4}; bus.use_ex_i = 2'b01;
    #3;
    check_eq("rst_ex_sel", 32'(bus.fw_ex_sel_o), 0);
    check_eq("rst_stall", 32'(bus.stall_o), 0);
    check_eq("rst_hist", bus.hist_data_o, 0);
    next_cyc();
    rst_n = 1;
    #1;

    // load-use: lw x5 in EX, add uses x5
    ex_load(5'd5); bus.id_vld_i = 1; bus.rs_id_i = {5'd0, 5'd5}; bus.use_ex_i = 2'b01;
    #1 check_eq("lu_stall_c1", 32'(bus.stall_o), 1);
    next_cyc();
    bus.regwr_me_i = 1; bus.memrd_me_i = 1; bus.rd_me_i = 5'd5;
    bus.id_vld_i = 1; bus.rs_id_i = {5'd0, 5'd5}; bus.use_ex_i = 2'b01;
    #1 check_eq("lu_stall_c2", 32'(bus.stall_o), 1);
    check_eq("lu_id_sel_meld", 32'(bus.fw_id_sel_o), 0);
    next_cyc();
    bus.regwr_wb_i = 1; bus.rd_wb_i = 5'd5; bus.wb_data_i = 32'h1234; bus.rs_ex_i = {5'd0, 5'd5};
    #1 check_eq("lu_stall_c3", 32'(bus.stall_o), 0);
    check_eq("lu_ex_sel_wb", 32'(bus.fw_ex_sel_o), 2);
    next_cyc();
`ifdef FWD_HAZARD_PERF_EN
    #1 check_eq("perf_stall_2", bus.perf_stall_cnt_o, 2);
    check_eq("perf_ld_1", bus.perf_ld_use_o, 1);
`endif

    // ME non-load beats WB
    bus.regwr_me_i = 1; bus.rd_me_i = 5'd7; bus.regwr_wb_i = 1; bus.rd_wb_i = 5'd7;
    bus.rs_ex_i = {5'd7, 5'd0}; bus.rs_id_i = {5'd7, 5'd0};
    #1 check_eq("me_over_wb_ex", 32'(bus.fw_ex_sel_o), 32'h4);
    check_eq("me_over_wb_id", 32'(bus.fw_id_sel_o), 32'h4);
    next_cyc();

    // HIST covers a producer that just left WB
    bus.regwr_wb_i = 1; bus.rd_wb_i = 5'd3; bus.wb_data_i = 32'hDEADBEEF;
    next_cyc();
    bus.rs_ex_i = {5'd0, 5'd3};
    #1 check_eq("hist_sel", 32'(bus.fw_ex_sel_o), 3);
    check_eq("hist_data", bus.hist_data_o, 32'hDEADBEEF);
    next_cyc();

    // compare-use: add x9 in EX, beq uses x9
    bus.regwr_ex_i = 1; bus.rd_ex_i = 5'd9;
    bus.id_vld_i = 1; bus.rs_id_i = {5'd9, 5'd0}; bus.use_cmp_i = 2'b10;
    #1 check_eq("cu_stall", 32'(bus.stall_o), 1);
    next_cyc();
    bus.regwr_me_i = 1; bus.rd_me_i = 5'd9;
    bus.id_vld_i = 1; bus.rs_id_i = {5'd9, 5'd0}; bus.use_cmp_i = 2'b10;
    #1 check_eq("cu_stall_done", 32'(bus.stall_o), 0);
    check_eq("cu_id_sel_me", 32'(bus.fw_id_sel_o), 32'h4);
    next_cyc();

    // x0 never stalls or forwards
    ex_load(5'd0); bus.id_vld_i = 1; bus.use_ex_i = 2'b11; bus.use_cmp_i = 2'b11;
    bus.regwr_me_i = 1; bus.rd_me_i = 5'd0; bus.regwr_wb_i = 1; bus.rd_wb_i = 5'd0;
    #1 check_eq("x0_stall", 32'(bus.stall_o), 0);
    check_eq("x0_ex_sel", 32'(bus.fw_ex_sel_o), 0);
    check_eq("x0_id_sel", 32'(bus.fw_id_sel_o), 0);
    next_cyc();

    // load in ME: one stall, no ME forwarding
    bus.regwr_me_i = 1; bus.memrd_me_i = 1; bus.rd_me_i = 5'd6; bus.rs_ex_i = {5'd0, 5'd6};
    bus.id_vld_i = 1; bus.rs_id_i = {5'd0, 5'd6}; bus.use_ex_i = 2'b01;
    #1 check_eq("meld_stall", 32'(bus.stall_o), 1);
    check_eq("meld_ex_sel", 32'(bus.fw_ex_sel_o), 0);
    next_cyc();
    #1 check_eq("meld_stall_end", 32'(bus.stall_o), 0);

    // flush in the second stall cycle
    ex_load(5'd5); bus.id_vld_i = 1; bus.rs_id_i = {5'd0, 5'd5}; bus.use_cmp_i = 2'b01;
    #1 check_eq("fl_stall_c1", 32'(bus.stall_o), 1);
    next_cyc();
    bus.flush_i = 1;
    #1 check_eq("fl_stall_c2", 32'(bus.stall_o), 0);
    next_cyc();
    #1 check_eq("fl_stall_c3", 32'(bus.stall_o), 0);

    // hold mid-stall extends it and freezes HIST
    ex_load(5'd5); bus.id_vld_i = 1; bus.rs_id_i = {5'd0, 5'd5}; bus.use_ex_i = 2'b01;
    #1 check_eq("hd_stall_c1", 32'(bus.stall_o), 1);
    next_cyc();
    bus.hold_i = 1; bus.regwr_wb_i = 1; bus.rd_wb_i = 5'd3; bus.wb_data_i = 32'hAAAA;
    #1 check_eq("hd_stall_held", 32'(bus.stall_o), 1);
    next_cyc();
    bus.rs_ex_i = {5'd0, 5'd3};
    #1 check_eq("hd_stall_c2", 32'(bus.stall_o), 1);
    check_eq("hd_hist_frozen", 32'(bus.fw_ex_sel_o), 0);
    next_cyc();
    #1 check_eq("hd_stall_end", 32'(bus.stall_o), 0);
`ifdef FWD_HAZARD_PERF_EN
    check_eq("perf_stall_7", bus.perf_stall_cnt_o, 7);
    check_eq("perf_ld_4", bus.perf_ld_use_o, 4);
`endif

    // reset mid-stall
    ex_load(5'd5); bus.id_vld_i = 1; bus.rs_id_i = {5'd0, 5'd5}; bus.use_ex_i = 2'b01;
    bus.regwr_wb_i = 1; bus.rd_wb_i = 5'd3; bus.wb_data_i = 32'hDEADBEEF;
    #1 check_eq("rs_stall_c1", 32'(bus.stall_o), 1);
    next_cyc();
    rst_n = 0;
    bus.regwr_me_i = 1; bus.rd_me_i = 5'd4; bus.rs_ex_i = {5'd0, 5'd4};
    #1 check_eq("rs_stall_low", 32'(bus.stall_o), 0);
    check_eq("rs_sel_low", 32'(bus.fw_ex_sel_o), 0);
    check_eq("rs_hist_low", bus.hist_data_o, 0);
    next_cyc();
    rst_n = 1;
    bus.rs_ex_i = {5'd0, 5'd3};
    #1 check_eq("rs_stall_after", 32'(bus.stall_o), 0);
    check_eq("rs_hist_vld_clr", 32'(bus.fw_ex_sel_o), 0);
    check_eq("rs_hist_data_clr", bus.hist_data_o, 0);
`ifdef FWD_HAZARD_PERF_EN
    check_eq("perf_stall_rst", bus.perf_stall_cnt_o, 0);
    check_eq("perf_ld_rst", bus.perf_ld_use_o, 0);
    next_cyc();
    ex_load(5'd5); bus.id_vld_i = 1; bus.rs_id_i = {5'd0, 5'd5}; bus.use_ex_i = 2'b01;
    next_cyc();
    next_cyc();
    #1 check_eq("perf_r2_exact", bus.perf_stall_cnt_o, 2);
    check_eq("perf_r2_ld", bus.perf_ld_use_o, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
